// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one 8-bit APB bus between N_REQ requesters,
// sequencing IDLE -> SETUP -> ACCESS with wait states and a PREADY timeout.
module apb_master_arbiter #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_write,
  input  logic [8*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     req_done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 tmo_abort,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [7:0]           paddr,
  output logic [7:0]           pwdata,
  input  logic [7:0]           prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]       state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    gnt_reg;
  logic [CW-1:0]    cnt_reg;
  logic [7:0]       paddr_reg;
  logic [7:0]       pwdata_reg;
  logic             pwrite_reg;
  logic [N_REQ-1:0] req_done_reg;
  logic [7:0]       rsp_rdata_reg;
  logic             rsp_err_reg;
  logic             tmo_abort_reg;

  logic [7:0]       addr_arr  [N_REQ];
  logic [7:0]       wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[8*gi +: 8];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  // Requester finishing this cycle is masked so it cannot be re-granted immediately.
  logic [N_REQ-1:0] eligible;
  logic             grant_found;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;

  always_comb begin
    eligible    = req_valid & ~req_done_reg;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr_reg) + k) % N_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  logic [IW-1:0] ptr_next;
  assign ptr_next = (gnt_reg == LAST_IDX) ? '0 : gnt_reg + 1'b1;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      cnt_reg       <= '0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pwrite_reg    <= 1'b0;
      req_done_reg  <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      tmo_abort_reg <= 1'b0;
    end else begin
      req_done_reg  <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      tmo_abort_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            gnt_reg    <= grant_idx;
            paddr_reg  <= addr_arr[grant_idx];
            pwrite_reg <= req_write[grant_idx];
            pwdata_reg <= req_write[grant_idx] ? wdata_arr[grant_idx] : 8'h00;
            state_reg  <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_reg   <= '0;
          state_reg <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= ptr_next;
            req_done_reg  <= N_REQ'(1) << gnt_reg;
            rsp_rdata_reg <= pwrite_reg ? 8'h00 : prdata;
            rsp_err_reg   <= pslverr;
          end else if (TIMEOUT_CYC != 0 && cnt_reg == TMO_LAST) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= ptr_next;
            req_done_reg  <= N_REQ'(1) << gnt_reg;
            rsp_err_reg   <= 1'b1;
            tmo_abort_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign psel      = (state_reg == S_SETUP) || (state_reg == S_ACCESS);
  assign penable   = (state_reg == S_ACCESS);
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign pwrite    = pwrite_reg;
  assign req_done  = req_done_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign tmo_abort = tmo_abort_reg;

endmodule
